// File: rtl/mult8_rr_scheduler.sv
// Round-robin scheduler that time-shares one external registered
// 8x8 multiplier among N requesters and returns tagged products in order.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   req/a_in/b_in     per-requester request and packed operands
//   gnt               one-hot combinational grant (request consumed)
//   mul_start/a/b     strobe and operands to the shared multiplier
//   mul_result        product from the multiplier, LAT cycles after start
//   resp_*            result FIFO head with valid/ready handshake
//   busy              work in flight or results still buffered
module mult8_rr_scheduler #(
    parameter int N          = 4,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*8-1:0] a_in,
    input  logic [N*8-1:0] b_in,
    output logic [N-1:0]   gnt,
    output logic           mul_start,
    output logic [7:0]     mul_a,
    output logic [7:0]     mul_b,
    input  logic [15:0]    mul_result,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [15:0]    resp_data,
    output logic [IDW-1:0] resp_id,
    output logic           busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           issue_ok;
    logic           grant;

    logic [LAT-1:0] pv;
    logic [IDW-1:0] pid [LAT];

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  inflight;
    logic [CW:0]    used;

    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [15:0]    fd [FIFO_DEPTH];
    logic [IDW-1:0] fi [FIFO_DEPTH];
    logic           push;
    logic           pop;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + CW'(pv[k]);
        end
    end

    // Credits come from registered state only, so a pop in this
    // cycle frees its slot one cycle later.
    assign used     = {1'b0, cnt} + {1'b0, inflight};
    assign issue_ok = (used < DEPTH_C);

    // First set request at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N);
            end
        end
    end

    assign grant     = rst && issue_ok && found;
    assign mul_start = grant;

    always_comb begin
        gnt   = '0;
        mul_a = '0;
        mul_b = '0;
        if (grant) begin
            gnt[win] = 1'b1;
            mul_a    = a_in[8*int'(win) +: 8];
            mul_b    = b_in[8*int'(win) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
        end
    end

    // ID pipeline mirrors the multiplier latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) begin
                pid[k] <= '0;
            end
        end else begin
            pv[0]  <= grant;
            pid[0] <= win;
            for (int k = 1; k < LAT; k++) begin
                pv[k]  <= pv[k-1];
                pid[k] <= pid[k-1];
            end
        end
    end

    assign push = pv[LAT-1];
    assign pop  = resp_valid && resp_ready;

    // The credit rule guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fd[k] <= '0;
                fi[k] <= '0;
            end
        end else begin
            if (push) begin
                fd[wp] <= mul_result;
                fi[wp] <= pid[LAT-1];
                wp     <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign resp_valid = (cnt != '0);
    assign resp_data  = fd[rp];
    assign resp_id    = fi[rp];
    assign busy       = (inflight != '0) || (cnt != '0);

endmodule

// File: tb/tb_mult8_rr_scheduler.sv
// Self-checking bench for mult8_rr_scheduler: directed vectors,
// corner sequences and a queue-based random reference model.
module tb_mult8_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req0, gnt0, req3, gnt3;
    logic [31:0] a0, b0, a3, b3;
    logic        s0, s3;
    logic [7:0]  ma0, mb0, ma3, mb3;
    logic [15:0] mr0, mr3;
    logic        v0, rdy0, v3, rdy3;
    logic [15:0] d0, d3;
    logic [1:0]  id0, id3;
    logic        busy0, busy3;
    logic [15:0] p3 [3];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        int id;
        int p;
        int g;
    } ent_t;

    vec_t tv [6];
    ent_t q [$];
    bit         pend [4];
    logic [7:0] oa [4];
    logic [7:0] ob [4];

    always #5 clk = ~clk;

    mult8_rr_scheduler #(.N(4), .LAT(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .req(req0), .a_in(a0), .b_in(b0),
        .gnt(gnt0), .mul_start(s0), .mul_a(ma0), .mul_b(mb0),
        .mul_result(mr0), .resp_valid(v0), .resp_ready(rdy0),
        .resp_data(d0), .resp_id(id0), .busy(busy0)
    );

    mult8_rr_scheduler #(.N(4), .LAT(3), .FIFO_DEPTH(8)) u3 (
        .clk(clk), .rst(rst), .req(req3), .a_in(a3), .b_in(b3),
        .gnt(gnt3), .mul_start(s3), .mul_a(ma3), .mul_b(mb3),
        .mul_result(mr3), .resp_valid(v3), .resp_ready(rdy3),
        .resp_data(d3), .resp_id(id3), .busy(busy3)
    );

    // External multipliers: LAT=1 registered, LAT=3 pipelined.
    always @(posedge clk) begin
        if (s0) mr0 <= 16'(ma0) * 16'(mb0);
        if (s3) p3[0] <= 16'(ma3) * 16'(mb3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mr3 = p3[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int win;
        int j;
        bit ev;

        tv[0] = '{0, 8'd12,  8'd10,  16'd120};
        tv[1] = '{2, 8'd255, 8'd255, 16'd65025};
        tv[2] = '{1, 8'd0,   8'd200, 16'd0};
        tv[3] = '{3, 8'd255, 8'd1,   16'd255};
        tv[4] = '{1, 8'd16,  8'd16,  16'd256};
        tv[5] = '{3, 8'd200, 8'd0,   16'd0};

        // Reset: requests present but nothing granted.
        rst = 1'b0; req0 = 4'hf; a0 = '0; b0 = '0; rdy0 = 1'b1;
        req3 = '0; a3 = '0; b3 = '0; rdy3 = 1'b1;
        nxt();
        smp();
        chk("rst_gnt", gnt0, 0);
        chk("rst_start", s0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_data", d0, 0);
        chk("rst_id", id0, 0);
        chk("rst_busy", busy0, 0);
        nxt();
        rst = 1'b1; req0 = '0;

        // Single-request vectors.
        for (int i = 0; i < 6; i++) begin
            req0 = 4'(1 << tv[i].id);
            a0 = 32'(tv[i].a) << (8 * tv[i].id);
            b0 = 32'(tv[i].b) << (8 * tv[i].id);
            smp();
            chk("tv_gnt", gnt0, 1 << tv[i].id);
            chk("tv_start", s0, 1);
            chk("tv_mula", ma0, tv[i].a);
            nxt();
            req0 = '0; a0 = '0; b0 = '0;
            smp();
            chk("tv_early", v0, 0);
            nxt();
            smp();
            chk("tv_valid", v0, 1);
            chk("tv_data", d0, tv[i].p);
            chk("tv_id", id0, tv[i].id);
            nxt();
            smp();
            chk("tv_done", v0, 0);
            chk("tv_busy", busy0, 0);
            nxt();
        end

        // Reset with 2 buffered and 1 in flight.
        rdy0 = 1'b0; req0 = 4'b0011;
        a0 = 32'h0000_0605; b0 = 32'h0000_0605;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("mr_gnt", gnt0, (k % 2 == 0) ? 1 : 2);
            nxt();
        end
        rst = 1'b0;
        smp();
        chk("mr_gnt_in_rst", gnt0, 0);
        chk("mr_busy_pre", busy0, 1);
        chk("mr_valid_pre", v0, 1);
        nxt();
        rst = 1'b1; req0 = '0; rdy0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("mr_valid_post", v0, 0);
            chk("mr_busy_post", busy0, 0);
            nxt();
        end

        // Round robin after reset starts at requester 0.
        a0 = 32'h0403_0201; b0 = 32'h0303_0303;
        for (int k = 0; k < 12; k++) begin
            req0 = (k < 10) ? 4'hf : 4'h0;
            smp();
            chk("rr_gnt", gnt0, (k < 10) ? (1 << (k % 4)) : 0);
            if (k >= 2) begin
                chk("rr_valid", v0, 1);
                chk("rr_data", d0, 3 * ((k - 2) % 4 + 1));
                chk("rr_id", id0, (k - 2) % 4);
            end
            nxt();
        end
        smp();
        chk("rr_busy", busy0, 0);
        nxt();

        // Backpressure: four grants, then credits run out.
        rdy0 = 1'b0; req0 = 4'b0011;
        a0 = 32'h0000_0B07; b0 = 32'h0000_0D09;
        for (int k = 0; k < 11; k++) begin
            if (k == 6) rdy0 = 1'b1;
            if (k == 8) req0 = '0;
            smp();
            if (k < 4)      chk("bp_gnt", gnt0, (k % 2 == 0) ? 1 : 2);
            else if (k == 7) chk("bp_resume", gnt0, 1);
            else            chk("bp_stall", gnt0, 0);
            if (k >= 2) chk("bp_valid", v0, 1);
            if (k >= 6 && k < 10) begin
                chk("bp_data", d0, (k % 2 == 0) ? 63 : 143);
                chk("bp_id", id0, k % 2);
            end
            if (k == 10) begin
                chk("bp_new_data", d0, 63);
                chk("bp_new_id", id0, 0);
            end
            nxt();
        end
        smp();
        chk("bp_busy", busy0, 0);
        nxt();

        // Random traffic against a queue model.
        rst = 1'b0;
        nxt();
        rst = 1'b1;
        j = 0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 2 == 1)) begin
                    pend[i] = 1'b1;
                    oa[i] = ($urandom % 8 == 0) ? 8'hff : 8'($urandom);
                    ob[i] = ($urandom % 8 == 0) ? 8'hff : 8'($urandom);
                end
            end
            for (int i = 0; i < 4; i++) begin
                req0[i] = pend[i];
                a0[8*i +: 8] = oa[i];
                b0[8*i +: 8] = ob[i];
            end
            rdy0 = ($urandom % 4) != 0;
            smp();
            win = -1;
            if (q.size() < 4) begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && pend[(j + k) % 4]) win = (j + k) % 4;
                end
            end
            chk("rnd_gnt", gnt0, (win < 0) ? 0 : (1 << win));
            ev = (q.size() > 0) && (cyc >= q[0].g + 2);
            chk("rnd_valid", v0, ev);
            if (ev) begin
                chk("rnd_data", d0, q[0].p);
                chk("rnd_id", id0, q[0].id);
            end
            chk("rnd_busy", busy0, q.size() != 0);
            if (ev && rdy0) void'(q.pop_front());
            if (win >= 0) begin
                q.push_back('{win, int'(oa[win]) * int'(ob[win]), cyc});
                pend[win] = 1'b0;
                j = (win + 1) % 4;
            end
            nxt();
        end
        req0 = '0;

        // LAT=3: continuous single requester.
        req3 = 4'b0100; a3 = 32'h0014_0000; b3 = 32'h0005_0000;
        rdy3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            smp();
            chk("l3_gnt", gnt3, 4);
            chk("l3_valid", v3, k >= 4);
            if (k >= 4) begin
                chk("l3_data", d3, 100);
                chk("l3_id", id3, 2);
            end
            nxt();
        end
        req3 = '0;
        for (int k = 0; k < 4; k++) nxt();
        smp();
        chk("l3_busy", busy3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
